// File: rtl/hps_img_loader.sv
// Loads the HPS source image into on-chip memory. Each 32-bit word pushed over a
// 4-phase req/ack handshake is split into four consecutive byte writes.
module hps_img_loader #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hps_start,
    input  logic              hps_req,
    input  logic [31:0]       hps_wdata,
    output logic              hps_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic [12:0]       word_count
);

    localparam logic [12:0] FRAME_WORDS = 13'(IMG_W * IMG_H / 4);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_REQ = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_ACK      = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_DONE_ACK = 3'd5;

    logic [1:0]        start_sync_q, req_sync_q;
    logic              start_prev_q;
    logic              start_edge, req_s;

    logic [2:0]        state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       word_q, word_d;
    logic [12:0]       wc_q, wc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              ack_q, ack_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    assign start_edge = start_sync_q[1] & ~start_prev_q;
    assign req_s      = req_sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            start_sync_q <= '0;
            req_sync_q   <= '0;
            start_prev_q <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[0], hps_start};
            req_sync_q   <= {req_sync_q[0], hps_req};
            start_prev_q <= start_sync_q[1];
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        word_d  = word_q;
        wc_d    = wc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        ack_d   = 1'b0;
        wren_d  = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        // A new start abandons whatever word is in flight, from any state.
        if (start_edge) begin
            state_d = S_WAIT_REQ;
            k_d     = 2'd0;
            wc_d    = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                S_WAIT_REQ: begin
                    if (req_s) begin
                        word_d  = hps_wdata;
                        k_d     = 2'd0;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    wren_d = 1'b1;
                    addr_d = ADDR_W'({wc_q, k_q});
                    data_d = word_q[8*k_q +: 8];
                    k_d    = k_q + 2'd1;
                    if (k_q == 2'd3) state_d = S_ACK;
                end
                S_ACK: begin
                    if (req_s) begin
                        ack_d = 1'b1;
                    end else begin
                        wc_d = wc_q + 13'd1;
                        if (wc_q == FRAME_WORDS - 13'd1) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_WAIT_REQ;
                        end
                    end
                end
                // Past the end of the frame words are still handshaked but discarded.
                S_DONE: begin
                    if (req_s) begin
                        ovr_d   = 1'b1;
                        state_d = S_DONE_ACK;
                    end
                end
                S_DONE_ACK: begin
                    if (req_s) ack_d = 1'b1;
                    else       state_d = S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            wc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ack_q   <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wc_q    <= wc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            ack_q   <= ack_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign hps_ack    = ack_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign mem_wren   = wren_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;
    assign word_count = wc_q;

endmodule

// File: doc/hps_img_loader.md
# hps_img_loader

Loads the 160×120, 8-bit source image from the HPS into the on-chip source image memory. The copier/scaler path reads this memory through `rom_addr`/`rom_data`. The HPS pushes 32-bit words over a 4-phase req/ack handshake. The block serialises each word into four byte writes at consecutive addresses, counts words, and flags frame completion and overrun.

## Interface
- `IMG_W`, 160, source image width in pixels
- `IMG_H`, 120, source image height in pixels
- `ADDR_W`, 15, byte address width of the source memory
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `hps_start`  in  1  level from HPS; rising edge (after sync) begins a new frame load
- `hps_req`  in  1  level from HPS; high means `hps_wdata` is valid
- `hps_wdata`  in  32  four packed pixels; byte 0 = `[7:0]` = lowest address
- `hps_ack`  out  1  handshake acknowledge to HPS
- `mem_addr`  out  ADDR_W  byte write address to source memory
- `mem_data`  out  8  byte write data
- `mem_wren`  out  1  write enable, one byte per cycle
- `busy`  out  1  high from accepted start until frame complete
- `frame_done`  out  1  sticky; set when the last word is written, cleared by start or reset
- `overrun`  out  1  sticky; set if a word arrives after frame complete
- `word_count`  out  13  words written in current frame (0..4800)

## Operation
- Frame size is `IMG_W*IMG_H/4` = 4800 words, or 19200 bytes at addresses 0..19199.
- `hps_start` and `hps_req` each pass through a 2-flop synchronizer. The start edge detector compares the synchronized start with its previous value.
- FSM states:
  - IDLE: reset state. `hps_req` is ignored and never acked.
  - On start edge, go to WAIT_REQ. Clear `word_count`, `frame_done` and `overrun`. Set `busy`.
  - WAIT_REQ: when synchronized req = 1, latch `hps_wdata` and go to WRITE with byte index k = 0.
  - WRITE: `mem_wren`=1, `mem_addr` = {word_count, k[1:0]}, `mem_data` = latched byte k. k increments each cycle. After k=3, go to ACK.
  - ACK: `hps_ack`=1. When synchronized req = 0, drop ack and increment `word_count`. If the new count is 4800, go to DONE with `frame_done`=1 and `busy`=0. Otherwise go to WAIT_REQ.
  - DONE: each req is still fully handshaked, so the HPS never hangs. No memory write occurs, `word_count` is unchanged, and `overrun` is set.
- Start edge in any state (including mid-WRITE or ACK) has priority:
  - the word in progress is abandoned, with no further writes;
  - `hps_ack` drops;
  - the FSM goes to WAIT_REQ with counters cleared.
  - The HPS must drop req before presenting the next word. A still-high req is treated as a new word.
- `mem_wren` is asserted only in WRITE. `mem_addr` and `mem_data` are don't-care otherwise but are held at 0.
- Arithmetic: `word_count` is 13-bit unsigned and never exceeds 4800. The address concatenation cannot overflow 15 bits.

## Timing
- Reset: all outputs 0, FSM in IDLE, synchronizers cleared.
- Req rising before edge E: sync output is visible after E+1, the FSM latches data at E+2, and `mem_wren` is high for the four cycles following edges E+3..E+6.
- `hps_ack` rises after edge E+7.
- Req falling before edge F: ack falls and `word_count` increments after edge F+2.
- Minimum handshake turnaround is 10 cycles per word. Full frame is at least 48000 cycles.
- `frame_done` and `busy` change on the same edge as the final `word_count` increment.
- Reset has priority over start. Reset mid-frame stops writes on the next edge.

## Test plan
- Reset then idle: pulse `hps_req` with no start → `hps_ack` stays 0, `mem_wren` never asserts, all outputs 0.
- Single word: start, then `hps_wdata`=0x44332211 → writes 0x11@0, 0x22@1, 0x33@2, 0x44@3 in 4 consecutive cycles; ack high after E+7; `word_count`=1 after req drop.
- Full frame: 4800 words with data = word index → byte 19199 written with last word's byte 3, `frame_done`=1, `busy`=0, `word_count`=4800.
- Overrun: a 4801st word after done → full handshake completes, no `mem_wren`, `overrun`=1, `word_count` stays 4800.
- Restart mid-frame: start edge during WRITE of word 100 → writes stop next cycle, `word_count`=0, next word writes to addresses 0..3, `frame_done`/`overrun` cleared.
- Reset mid-handshake: reset while `hps_ack`=1 → next cycle ack=0, `busy`=0, `word_count`=0, FSM IDLE.
